desplazador_multimodo: RTL and testbench
========================================

DESPLAZADOR_MULTIMODO -- requirements
Module: desplazador_multimodo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, data width in bits (minimum 2).
REQ-002 The block SHALL have parameter SHAMT_W, default 4, shift-amount width in bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, operand request.
REQ-006 The block SHALL have port in_ready, output, 1, block can accept an operand.
REQ-007 The block SHALL have port DATO, input, WIDTH, operand.
REQ-008 The block SHALL have port shamt, input, SHAMT_W, requested shift amount.
REQ-009 The block SHALL have port modo, input, 2, operation: 00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
REQ-010 The block SHALL have port out_valid, output, 1, result available.
REQ-011 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 The block SHALL have port RESULTADO, output, WIDTH, shifted result.

Function
REQ-013 The block SHALL accept an operand on a rising edge with in_valid=1 and in_ready=1, registering DATO, modo and the effective count.
REQ-014 Effective count SHALL be shamt mod WIDTH for rotate, and min(shamt, WIDTH) for the other modes.
REQ-015 The FSM SHALL have states IDLE, SHIFT and DONE: IDLE->SHIFT on accept with count>0; IDLE->DONE on accept with count=0; SHIFT->DONE when the remaining count reaches 0; DONE->IDLE on out_valid=1 and out_ready=1.
REQ-016 In SHIFT the block SHALL shift by exactly one position per cycle and decrement the remaining count.
REQ-017 Logical shifts SHALL fill with 0, arithmetic right SHALL fill with the operand MSB, and rotate SHALL wrap bit 0 into bit WIDTH-1.
REQ-018 out_valid SHALL rise count+1 cycles after the accepting edge.
REQ-019 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-020 While out_valid=1 and out_ready=0, RESULTADO and all flags SHALL hold stable.
REQ-021 Inputs other than out_ready SHALL be ignored outside IDLE.

Reset
REQ-022 Asserting rst SHALL, at any time including mid-SHIFT, immediately force the FSM to IDLE, out_valid=0, RESULTADO=0 and flags=0, with in_ready=1 after rst deasserts.
REQ-023 An operation interrupted by reset SHALL be discarded and no result SHALL be produced for it.

Configuration
REQ-024 With macro DESPLAZADOR_FLAGS_EN defined, outputs ACARREO (1 bit, last bit shifted or rotated out, 0 if count=0) and CERO (1 bit, RESULTADO==0) SHALL exist, be valid with out_valid and hold with RESULTADO.
REQ-025 Without DESPLAZADOR_FLAGS_EN, those ports and their logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-026 Package desplazador_pkg SHALL hold the modo_t enum (four modes), the estado_t FSM enum and the mode encoding constants.
REQ-027 Single-position shifting SHALL be a combinational sub-module desplazador_paso (inputs: value, modo; outputs: next value, bit out), instantiated once.

Verification (WIDTH=10, SHAMT_W=4)
REQ-028 Logical right of 10'b1011001110 by 3 SHALL give RESULTADO=10'b0001011001 with out_valid 4 cycles after accept and ACARREO=1.
REQ-029 Arithmetic right of 10'b1000000000 by 12 SHALL use count 10 and give 10'b1111111111 with out_valid 11 cycles after accept.
REQ-030 Rotate right of 10'b0000000001 by 11 SHALL use count 1 and give 10'b1000000000 with out_valid 2 cycles after accept.
REQ-031 Logical left of 10'b0000000011 by 9 SHALL give 10'b1000000000 with CERO=0; a shift of 0 SHALL give out_valid 1 cycle after accept with DATO unchanged.
REQ-032 With out_ready held 0 for 5 cycles in DONE, the bench SHALL see RESULTADO stable, in_ready=0 and a new in_valid ignored; the first out_ready=1 edge SHALL give in_ready=1.
REQ-033 rst asserted on the 2nd SHIFT cycle of a 7-position shift SHALL drop out_valid and RESULTADO to 0 immediately, and no result SHALL appear afterwards.

Source files
------------

// File: rtl/desplazador_pkg.sv
// desplazador_pkg -- shared types for the multi-mode shifter.
//   MODO_*   : 2-bit operation encodings (modo port)
//   modo_t   : operation enum built from those encodings
//   estado_t : FSM states of desplazador_multimodo
package desplazador_pkg;

    localparam logic [1:0] MODO_LSR = 2'b00; // logical right
    localparam logic [1:0] MODO_ASR = 2'b01; // arithmetic right
    localparam logic [1:0] MODO_LSL = 2'b10; // logical left
    localparam logic [1:0] MODO_ROR = 2'b11; // rotate right

    typedef enum logic [1:0] {
        M_LSR = MODO_LSR,
        M_ASR = MODO_ASR,
        M_LSL = MODO_LSL,
        M_ROR = MODO_ROR
    } modo_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } estado_t;

endpackage

// File: rtl/desplazador_paso.sv
// desplazador_paso -- one-position shift step (purely combinational).
//   valor      : current value
//   modo       : operation
//   siguiente  : value after one position
//   bit_salida : bit that leaves the word in this step
module desplazador_paso
    import desplazador_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] valor,
    input  modo_t            modo,
    output logic [WIDTH-1:0] siguiente,
    output logic             bit_salida
);

    always_comb begin
        siguiente  = valor;
        bit_salida = 1'b0;
        case (modo)
            M_LSR: begin
                siguiente  = {1'b0, valor[WIDTH-1:1]};
                bit_salida = valor[0];
            end
            M_ASR: begin
                siguiente  = {valor[WIDTH-1], valor[WIDTH-1:1]};
                bit_salida = valor[0];
            end
            M_LSL: begin
                siguiente  = {valor[WIDTH-2:0], 1'b0};
                bit_salida = valor[WIDTH-1];
            end
            M_ROR: begin
                siguiente  = {valor[0], valor[WIDTH-1:1]};
                bit_salida = valor[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/desplazador_multimodo.sv
// desplazador_multimodo -- sequential multi-mode shifter, one position per cycle.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (DATO, shamt, modo)
//   out_valid/out_ready : result handshake (RESULTADO)
//   ACARREO, CERO       : last bit out / zero result, only when
//                         DESPLAZADOR_FLAGS_EN is defined
// RESULTADO is the working register; it is only meaningful with out_valid.
module desplazador_multimodo
    import desplazador_pkg::*;
#(
    parameter int WIDTH   = 10,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   DATO,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         modo,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   RESULTADO
`ifdef DESPLAZADOR_FLAGS_EN
    ,
    output logic               ACARREO,
    output logic               CERO
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    estado_t           estado, estado_sig;
    logic [WIDTH-1:0]  dato_r;
    modo_t             modo_r;
    logic [CNT_W-1:0]  resta;
    logic [CNT_W-1:0]  cnt_eff;
    logic [31:0]       shamt32;
    logic [WIDTH-1:0]  paso_sig;
    logic              paso_bit;

    // Rotation by WIDTH is the identity, so rotate wraps; shifts saturate
    // at WIDTH where the word is fully flushed.
    always_comb begin
        shamt32 = 32'(shamt);
        if (modo == MODO_ROR)
            cnt_eff = CNT_W'(shamt32 % 32'(WIDTH));
        else if (shamt32 > 32'(WIDTH))
            cnt_eff = CNT_W'(WIDTH);
        else
            cnt_eff = CNT_W'(shamt32);
    end

    desplazador_paso #(.WIDTH(WIDTH)) u_paso (
        .valor      (dato_r),
        .modo       (modo_r),
        .siguiente  (paso_sig),
        .bit_salida (paso_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) estado <= IDLE;
        else     estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (estado)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    estado_sig = (cnt_eff == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                // the step taken on this edge is the last one
                if (resta == CNT_W'(1)) estado_sig = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) estado_sig = IDLE;
            end
            default: estado_sig = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dato_r <= '0;
            modo_r <= M_LSR;
            resta  <= '0;
        end else begin
            case (estado)
                IDLE: if (in_valid) begin
                    dato_r <= DATO;
                    modo_r <= modo_t'(modo);
                    resta  <= cnt_eff;
                end
                SHIFT: begin
                    dato_r <= paso_sig;
                    resta  <= resta - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign RESULTADO = dato_r;

`ifdef DESPLAZADOR_FLAGS_EN
    // CERO is registered rather than decoded from RESULTADO so that it
    // reads 0 after reset while RESULTADO is also 0.
    logic acarreo_r, cero_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acarreo_r <= 1'b0;
            cero_r    <= 1'b0;
        end else begin
            case (estado)
                IDLE: if (in_valid) begin
                    acarreo_r <= 1'b0;
                    cero_r    <= (cnt_eff == '0) && (DATO == '0);
                end
                SHIFT: begin
                    acarreo_r <= paso_bit;
                    if (resta == CNT_W'(1)) cero_r <= (paso_sig == '0);
                end
                default: ;
            endcase
        end
    end

    assign ACARREO = acarreo_r;
    assign CERO    = cero_r;
`else
    logic paso_bit_unused;
    assign paso_bit_unused = paso_bit;
`endif

endmodule

// File: tb/tb_desplazador_multimodo.sv
// tb_desplazador_multimodo -- directed self-checking bench (WIDTH=10, SHAMT_W=4).
// Flag checks are compiled in when DESPLAZADOR_FLAGS_EN is defined.
module tb_desplazador_multimodo;

    localparam int WIDTH   = 10;
    localparam int SHAMT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   DATO;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         modo;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   RESULTADO;
`ifdef DESPLAZADOR_FLAGS_EN
    logic               ACARREO;
    logic               CERO;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    desplazador_multimodo #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .DATO      (DATO),
        .shamt     (shamt),
        .modo      (modo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .RESULTADO (RESULTADO)
`ifdef DESPLAZADOR_FLAGS_EN
        ,
        .ACARREO   (ACARREO),
        .CERO      (CERO)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency (cycles sampled after the
    // accepting edge until out_valid), result and flags, then consume it.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] d,
                          input logic [SHAMT_W-1:0] s, input logic [1:0] m,
                          input logic [WIDTH-1:0] exp_res, input int exp_cyc,
                          input logic exp_c, input logic exp_z);
        int cyc;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        DATO = d; shamt = s; modo = m; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; DATO = '1; shamt = '1; modo = 2'b00;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 40);
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_res"}, 32'(RESULTADO), 32'(exp_res));
`ifdef DESPLAZADOR_FLAGS_EN
        chk({tag, "_acarreo"}, 32'(ACARREO), 32'(exp_c));
        chk({tag, "_cero"}, 32'(CERO), 32'(exp_z));
`else
        if (exp_c === 1'bx || exp_z === 1'bx) $display("note: flag expectations undefined");
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_ret_idle"}, 32'({in_ready, out_valid}), 32'b10);
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        rst = 1'b1; in_valid = 1'b0; DATO = '0; shamt = '0; modo = 2'b00; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(RESULTADO), 32'd0);
`ifdef DESPLAZADOR_FLAGS_EN
        chk("rst_flags", 32'({ACARREO, CERO}), 32'd0);
`endif
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        //        tag     DATO           shamt mode   expected       cyc C  Z
        run_op("lsr3",  10'b1011001110, 4'd3,  2'b00, 10'b0001011001, 4, 1, 0);
        run_op("asr12", 10'b1000000000, 4'd12, 2'b01, 10'b1111111111, 11, 1, 0);
        run_op("ror11", 10'b0000000001, 4'd11, 2'b11, 10'b1000000000, 2, 1, 0);
        run_op("lsl9",  10'b0000000011, 4'd9,  2'b10, 10'b1000000000, 10, 1, 0);
        run_op("sh0",   10'b1010101010, 4'd0,  2'b00, 10'b1010101010, 1, 0, 0);
        run_op("lsl15", 10'b0000000001, 4'd15, 2'b10, 10'b0000000000, 11, 1, 1);
        run_op("ror10", 10'b1100000011, 4'd10, 2'b11, 10'b1100000011, 1, 0, 0);
        run_op("asr4",  10'b0111111111, 4'd4,  2'b01, 10'b0000011111, 5, 1, 0);

        // Back-pressure: result held, new request ignored.
        @(negedge clk);
        DATO = 10'b1111111111; shamt = 4'd2; modo = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        #1 DATO = 10'b0000000001; shamt = 4'd0; modo = 2'b10;
        repeat (3) @(negedge clk);
        chk("stall_valid", 32'(out_valid), 32'd1);
        held = RESULTADO;
        chk("stall_res0", 32'(held), 32'(10'b0011111111));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", 32'({out_valid, in_ready, RESULTADO}), 32'({1'b1, 1'b0, 10'b0011111111}));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("stall_release", 32'({in_ready, out_valid}), 32'b10);

        // Reset in the 2nd SHIFT cycle of a 7-position shift.
        @(negedge clk);
        DATO = 10'b1111111111; shamt = 4'd7; modo = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        chk("rstmid_res", 32'(RESULTADO), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("rstmid_in_ready", 32'(in_ready), 32'd1);
        begin
            int seen = 0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("rstmid_no_result", 32'(seen), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
